dmem_arbiter: RTL

Shares the single-port data memory between the pipeline MEM stage (CPU port) and a debug/loader port (DBG port). Arbitration is round-robin, and each access runs as one transaction through a small FSM that models a fixed memory read latency. While the CPU access is pending, the block stalls the pipeline.

---
 rtl/dmem_arb_pkg.sv | 23 ++
 rtl/dmem_arbiter_if.sv | 50 +++++
 rtl/rr_arb2.sv | 21 ++
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM encoding,
// owner identifiers and the legal range of the memory read latency.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    localparam int LAT_W       = 4;
    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 15;

    function automatic bit lat_legal(input int lat);
        return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU port, debug port and memory port seen by the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dmem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cpu_stall;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_ack;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  owner
    );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick. req[0] is the CPU, req[1] the
// debug port; on a tie the port that did not own the last access wins.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       grant_valid,
    output logic       grant_owner
);

    logic [1:0] win;

    for (genvar gi = 0; gi < 2; gi++) begin : g_win
        assign win[gi] = req[gi] & (~req[1-gi] | (last_owner != 1'(gi)));
    end

    assign grant_valid = |win;
    assign grant_owner = win[1] ? OWN_DBG : OWN_CPU;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the CPU MEM stage and
// a debug/loader port; each access runs IDLE -> ISSUE -> WAIT -> RESP.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    if (!lat_legal(MEM_LAT)) begin : g_bad_lat
        $error("dmem_arbiter: MEM_LAT must be within 1..15");
    end

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

    state_t           state_reg, state_next;
    logic             owner_reg, owner_next;
    logic             last_owner_reg, last_owner_next;
    logic             we_reg, we_next;
    logic [AW-1:0]    addr_reg, addr_next;
    logic [DW-1:0]    wdata_reg, wdata_next;
    logic [DW-1:0]    rdata_reg, rdata_next;
    logic [LAT_W-1:0] lat_cnt_reg, lat_cnt_next;

    logic grant_valid;
    logic grant_owner;
    logic mem_en;
    logic resp;
    logic cpu_ack;

    rr_arb2 u_rr_arb2 (
        .req         ({bus.dbg_req, bus.cpu_req}),
        .last_owner  (last_owner_reg),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= OWN_CPU;
            last_owner_reg <= OWN_DBG;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
            lat_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            rdata_reg      <= rdata_next;
            lat_cnt_reg    <= lat_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        rdata_next      = rdata_reg;
        lat_cnt_next    = lat_cnt_reg;
        mem_en          = 1'b0;
        resp            = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (grant_valid) begin
                    owner_next = grant_owner;
                    we_next    = (grant_owner == OWN_DBG) ? bus.dbg_we    : bus.cpu_we;
                    addr_next  = (grant_owner == OWN_DBG) ? bus.dbg_addr  : bus.cpu_addr;
                    wdata_next = (grant_owner == OWN_DBG) ? bus.dbg_wdata : bus.cpu_wdata;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_en       = 1'b1;
                lat_cnt_next = LAT_LOAD;
                state_next   = ST_WAIT;
            end
            ST_WAIT: begin
                // Counter reaches zero in the cycle mem_rdata becomes valid.
                if (lat_cnt_reg == '0) begin
                    if (!we_reg) begin
                        rdata_next = bus.mem_rdata;
                    end
                    state_next = ST_RESP;
                end else begin
                    lat_cnt_next = lat_cnt_reg - 1'b1;
                end
            end
            ST_RESP: begin
                resp            = 1'b1;
                last_owner_next = owner_reg;
                state_next      = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign cpu_ack       = resp & (owner_reg == OWN_CPU);
    assign bus.cpu_ack   = cpu_ack;
    assign bus.dbg_ack   = resp & (owner_reg == OWN_DBG);
    assign bus.cpu_rdata = rdata_reg;
    assign bus.dbg_rdata = rdata_reg;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_ack;

    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_en & we_reg;
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;
    assign bus.owner     = owner_reg;

endmodule
